// File: rtl/im_line_fill.sv
// -----------------------------------------------------------------------------
// im_line_fill
//
// Single-line instruction fetch buffer. A fetch that hits the buffered line is
// answered on the next cycle. A miss issues a one-cycle burst read of the whole
// line to instruction memory. The line is captured as the words stream back,
// and then the requested word is returned. Aborted fills (wait timeout or a
// burst that stops early) raise a one-cycle error pulse and leave the line
// invalid.
//
// Parameters
//   data_size    : instruction word width
//   mem_size_bit : byte-address width
//   line_words   : words per line (16 words of 32 bits is a 64-byte line)
//   timeout      : maximum WAIT cycles with IM_ready low before aborting
//
// Ports
//   clock        in   single clock, all logic on the rising edge
//   reset        in   synchronous, active-high
//   cpu_req      in   fetch request, sampled only while idle
//   cpu_addr     in   fetch byte address (bits [1:0] ignored)
//   cpu_instr    out  fetched word, meaningful while cpu_valid is high
//   cpu_valid    out  one-cycle pulse, cpu_instr is valid
//   invalidate   in   discard the buffered line
//   fill_busy    out  high in every state other than IDLE
//   fill_error   out  one-cycle pulse on an aborted fill
//   IM_enable    out  memory enable (one cycle per burst)
//   IM_read      out  memory read strobe (one cycle per burst)
//   IM_write     out  tied low
//   IM_address   out  line base byte address of the last burst
//   IM_in        out  tied low
//   IM_out       in   burst data from memory
//   IM_ready     in   high for each consecutive burst word
// -----------------------------------------------------------------------------
module im_line_fill #(
  parameter int data_size    = 32,
  parameter int mem_size_bit = 12,
  parameter int line_words   = 16,
  parameter int timeout      = 31
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    cpu_req,
  input  logic [mem_size_bit-1:0] cpu_addr,
  output logic [data_size-1:0]    cpu_instr,
  output logic                    cpu_valid,
  input  logic                    invalidate,
  output logic                    fill_busy,
  output logic                    fill_error,
  output logic                    IM_enable,
  output logic                    IM_read,
  output logic                    IM_write,
  output logic [mem_size_bit-1:0] IM_address,
  output logic [data_size-1:0]    IM_in,
  input  logic [data_size-1:0]    IM_out,
  input  logic                    IM_ready
);

  // Address split: word index inside the line, then the tag above it.
  localparam int IDX_W = $clog2(line_words);
  localparam int OFF_W = IDX_W + 2;
  localparam int TAG_W = mem_size_bit - OFF_W;
  localparam int TO_W  = (timeout < 1) ? 1 : $clog2(timeout + 1);

  localparam logic [TO_W-1:0]  TIMEOUT_C = TO_W'(timeout);
  localparam logic [IDX_W-1:0] LAST_C    = IDX_W'(line_words - 1);
  localparam logic [IDX_W-1:0] IDX_ZERO  = {IDX_W{1'b0}};
  localparam logic [TO_W-1:0]  TO_ZERO   = {TO_W{1'b0}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_FILL = 2'd3
  } state_t;

  state_t                  state_r;
  logic [data_size-1:0]    line_r [line_words];
  logic [TAG_W-1:0]        tag_r;
  logic                    valid_r;
  logic [TAG_W-1:0]        req_tag_r;
  logic [IDX_W-1:0]        req_idx_r;
  logic [IDX_W-1:0]        count_r;
  logic [TO_W-1:0]         wait_cnt_r;
  logic                    inv_pending_r;
  logic [data_size-1:0]    cpu_instr_r;
  logic                    cpu_valid_r;
  logic                    fill_error_r;
  logic                    im_enable_r;
  logic                    im_read_r;
  logic [mem_size_bit-1:0] im_address_r;

  logic [TAG_W-1:0]        addr_tag_s;
  logic [IDX_W-1:0]        addr_idx_s;
  logic                    hit_s;
  logic                    wr_en_s;
  logic [IDX_W-1:0]        wr_idx_s;
  logic                    unused_addr_s;

  // Byte offset within a word carries no information for word fetches.
  assign unused_addr_s = ^cpu_addr[1:0];

  assign addr_tag_s = cpu_addr[mem_size_bit-1:OFF_W];
  assign addr_idx_s = cpu_addr[OFF_W-1:2];

  // An invalidate in the same cycle wins over a hit, turning it into a miss.
  assign hit_s = cpu_req & valid_r & (tag_r == addr_tag_s) & ~invalidate;

  assign cpu_instr  = cpu_instr_r;
  assign cpu_valid  = cpu_valid_r;
  assign fill_error = fill_error_r;
  assign fill_busy  = (state_r != S_IDLE);
  assign IM_enable  = im_enable_r;
  assign IM_read    = im_read_r;
  assign IM_address = im_address_r;
  assign IM_write   = 1'b0;
  assign IM_in      = {data_size{1'b0}};

  // Line buffer write port: the first word lands in slot 0, the rest at count.
  always_comb begin
    wr_en_s  = 1'b0;
    wr_idx_s = IDX_ZERO;
    case (state_r)
      S_WAIT: begin
        if (IM_ready && !reset) begin
          wr_en_s  = 1'b1;
          wr_idx_s = IDX_ZERO;
        end else begin
          wr_en_s  = 1'b0;
        end
      end
      S_FILL: begin
        if (IM_ready && !reset) begin
          wr_en_s  = 1'b1;
          wr_idx_s = count_r;
        end else begin
          wr_en_s  = 1'b0;
        end
      end
      default: begin
        wr_en_s  = 1'b0;
        wr_idx_s = IDX_ZERO;
      end
    endcase
  end

  // Line buffer storage; its contents deliberately survive reset.
  always_ff @(posedge clock) begin
    if (wr_en_s) begin
      line_r[wr_idx_s] <= IM_out;
    end
  end

  // Fill controller with registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r       <= S_IDLE;
      tag_r         <= {TAG_W{1'b0}};
      valid_r       <= 1'b0;
      req_tag_r     <= {TAG_W{1'b0}};
      req_idx_r     <= IDX_ZERO;
      count_r       <= IDX_ZERO;
      wait_cnt_r    <= TO_ZERO;
      inv_pending_r <= 1'b0;
      cpu_instr_r   <= {data_size{1'b0}};
      cpu_valid_r   <= 1'b0;
      fill_error_r  <= 1'b0;
      im_enable_r   <= 1'b0;
      im_read_r     <= 1'b0;
      im_address_r  <= {mem_size_bit{1'b0}};
    end else begin
      // Pulses and strobes default low; each state raises what it needs.
      cpu_valid_r  <= 1'b0;
      fill_error_r <= 1'b0;
      im_enable_r  <= 1'b0;
      im_read_r    <= 1'b0;

      case (state_r)
        S_IDLE: begin
          if (invalidate) begin
            valid_r <= 1'b0;
          end
          if (cpu_req) begin
            if (hit_s) begin
              cpu_valid_r <= 1'b1;
              cpu_instr_r <= line_r[addr_idx_s];
            end else begin
              // Strobes are raised here so they are high exactly during REQ.
              req_tag_r     <= addr_tag_s;
              req_idx_r     <= addr_idx_s;
              inv_pending_r <= 1'b0;
              im_enable_r   <= 1'b1;
              im_read_r     <= 1'b1;
              im_address_r  <= {addr_tag_s, {OFF_W{1'b0}}};
              state_r       <= S_REQ;
            end
          end
        end

        S_REQ: begin
          valid_r    <= 1'b0;
          wait_cnt_r <= TO_ZERO;
          count_r    <= IDX_ZERO;
          if (invalidate) begin
            inv_pending_r <= 1'b1;
          end
          state_r <= S_WAIT;
        end

        S_WAIT: begin
          if (invalidate) begin
            inv_pending_r <= 1'b1;
          end
          if (IM_ready) begin
            count_r <= IDX_W'(1);
            state_r <= S_FILL;
          end else if (wait_cnt_r == TIMEOUT_C) begin
            // wait_cnt_r counts from 0, so this is WAIT cycle timeout+1.
            fill_error_r <= 1'b1;
            valid_r      <= 1'b0;
            state_r      <= S_IDLE;
          end else begin
            wait_cnt_r <= wait_cnt_r + TO_W'(1);
          end
        end

        S_FILL: begin
          if (invalidate) begin
            inv_pending_r <= 1'b1;
          end
          if (IM_ready) begin
            count_r <= count_r + IDX_W'(1);
            if (count_r == LAST_C) begin
              // Last word: the requested slot may be the word arriving now.
              valid_r     <= ~(inv_pending_r | invalidate);
              tag_r       <= req_tag_r;
              cpu_valid_r <= 1'b1;
              cpu_instr_r <= (req_idx_r == count_r) ? IM_out : line_r[req_idx_r];
              state_r     <= S_IDLE;
            end
          end else begin
            // Burst stopped before the line was complete.
            fill_error_r <= 1'b1;
            valid_r      <= 1'b0;
            state_r      <= S_IDLE;
          end
        end

        default: begin
          valid_r <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_im_line_fill.sv
module tb_im_line_fill;

  localparam int K_REQ  = 0;
  localparam int K_RESP = 1;
  localparam int K_ERR  = 2;

  logic        clock;
  logic        reset;
  logic        cpu_req;
  logic [11:0] cpu_addr;
  logic [31:0] cpu_instr;
  logic        cpu_valid;
  logic        invalidate;
  logic        fill_busy;
  logic        fill_error;
  logic        IM_enable;
  logic        IM_read;
  logic        IM_write;
  logic [11:0] IM_address;
  logic [31:0] IM_in;
  logic [31:0] IM_out;
  logic        IM_ready;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int mem_words   = 16;
  int mem_extra   = 0;

  typedef struct {
    int          kind;
    int          cyc;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];

  im_line_fill dut (
    .clock      (clock),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_addr   (cpu_addr),
    .cpu_instr  (cpu_instr),
    .cpu_valid  (cpu_valid),
    .invalidate (invalidate),
    .fill_busy  (fill_busy),
    .fill_error (fill_error),
    .IM_enable  (IM_enable),
    .IM_read    (IM_read),
    .IM_write   (IM_write),
    .IM_address (IM_address),
    .IM_in      (IM_in),
    .IM_out     (IM_out),
    .IM_ready   (IM_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic string kname(input int k);
    case (k)
      K_REQ:   return "mem_req";
      K_RESP:  return "cpu_resp";
      K_ERR:   return "fill_err";
      default: return "unknown";
    endcase
  endfunction

  task automatic push(input int kind, input int c, input logic [31:0] v);
    exp_t e;
    e.kind = kind;
    e.cyc  = c;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Scoreboard monitor: every output event is matched against the queue head.
  task automatic got_event(input int kind, input logic [31:0] v);
    exp_t e;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL unexpected_%s: got val=%h at cycle %0d, expected no event", kname(kind), v, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cyc != cyc || e.val !== v) begin
        miscompares++;
        $display("FAIL %s: got %s val=%h cycle %0d, expected %s val=%h cycle %0d",
                 kname(e.kind), kname(kind), v, cyc, kname(e.kind), e.val, e.cyc);
      end
    end
  endtask

  always @(negedge clock) begin
    if (IM_enable === 1'b1) got_event(K_REQ, 32'h0001_0000 * {31'd0, IM_read} | {20'd0, IM_address});
    if (cpu_valid === 1'b1) got_event(K_RESP, cpu_instr);
    if (fill_error === 1'b1) got_event(K_ERR, 32'd0);
  end

  // Memory model: 2 wait states after the request is sampled, then a burst.
  initial begin : mem_model
    int base;
    IM_ready = 1'b0;
    IM_out   = 32'd0;
    forever begin
      @(negedge clock);
      if (IM_enable === 1'b1) begin
        base = int'(IM_address) >> 2;
        repeat (3) @(posedge clock);
        #1;
        for (int i = 0; i < mem_words + mem_extra; i++) begin
          IM_ready = 1'b1;
          IM_out   = 32'hA000_0000 + 32'(base + i);
          @(posedge clock);
          #1;
        end
        IM_ready = 1'b0;
        IM_out   = 32'd0;
      end
    end
  end

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic issue(input logic [11:0] a, output int c0);
    c0       = cyc;
    cpu_addr = a;
    cpu_req  = 1'b1;
    @(posedge clock);
    #1;
    cpu_req  = 1'b0;
  endtask

  task automatic miss(input logic [11:0] a, input logic [31:0] d);
    int c0;
    push(K_REQ, cyc + 1, 32'h0001_0000 | {20'd0, a & 12'hFC0});
    push(K_RESP, cyc + 20, d);
    issue(a, c0);
    goto(c0 + 24);
  endtask

  task automatic hit(input logic [11:0] a, input logic [31:0] d);
    int c0;
    push(K_RESP, cyc + 1, d);
    issue(a, c0);
    goto(c0 + 3);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int c0;
    reset      = 1'b1;
    cpu_req    = 1'b0;
    cpu_addr   = 12'h000;
    invalidate = 1'b0;

    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_cpu_valid", {31'd0, cpu_valid}, 32'd0);
    chk("rst_cpu_instr", cpu_instr, 32'd0);
    chk("rst_fill_error", {31'd0, fill_error}, 32'd0);
    chk("rst_im_enable", {31'd0, IM_enable}, 32'd0);
    chk("rst_im_read", {31'd0, IM_read}, 32'd0);
    chk("rst_im_address", {20'd0, IM_address}, 32'd0);
    chk("rst_fill_busy", {31'd0, fill_busy}, 32'd0);
    chk("tie_im_write", {31'd0, IM_write}, 32'd0);
    chk("tie_im_in", IM_in, 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    goto(cyc + 2);

    // Cold miss with a request presented mid-fill that must be ignored
    push(K_REQ, cyc + 1, 32'h0001_0040);
    push(K_RESP, cyc + 20, 32'hA000_0012);
    issue(12'h048, c0);
    goto(c0 + 6);
    cpu_addr = 12'h07C;
    cpu_req  = 1'b1;
    goto(c0 + 7);
    cpu_req  = 1'b0;
    goto(c0 + 10);
    @(negedge clock);
    chk("busy_mid_fill", {31'd0, fill_busy}, 32'd1);
    goto(c0 + 24);

    // Hits on the buffered line
    hit(12'h07C, 32'hA000_001F);
    hit(12'h048, 32'hA000_0012);
    hit(12'h040, 32'hA000_0010);

    // Conflict miss, then hit the new line
    miss(12'h084, 32'hA000_0021);
    hit(12'h0BC, 32'hA000_002F);

    // Old line was replaced; refill with extra ready cycles that must be ignored
    mem_extra = 3;
    miss(12'h048, 32'hA000_0012);
    mem_extra = 0;
    hit(12'h040, 32'hA000_0010);
    hit(12'h07C, 32'hA000_001F);

    // Timeout: no ready at all, error after 32 WAIT cycles
    mem_words = 0;
    push(K_REQ, cyc + 1, 32'h0001_0100);
    push(K_ERR, cyc + 34, 32'd0);
    issue(12'h100, c0);
    goto(c0 + 40);
    mem_words = 16;
    miss(12'h100, 32'hA000_0040);

    // Early drop after 9 words, then the same line must be refetched
    mem_words = 9;
    push(K_REQ, cyc + 1, 32'h0001_0200);
    push(K_ERR, cyc + 14, 32'd0);
    issue(12'h200, c0);
    goto(c0 + 20);
    mem_words = 16;
    miss(12'h204, 32'hA000_0081);

    // Invalidate during a good fill: data delivered, line left invalid
    push(K_REQ, cyc + 1, 32'h0001_0300);
    push(K_RESP, cyc + 20, 32'hA000_00C0);
    issue(12'h300, c0);
    goto(c0 + 8);
    invalidate = 1'b1;
    goto(c0 + 9);
    invalidate = 1'b0;
    goto(c0 + 24);
    miss(12'h304, 32'hA000_00C1);

    // Invalidate in the same cycle as a would-be hit turns it into a miss
    invalidate = 1'b1;
    push(K_REQ, cyc + 1, 32'h0001_0300);
    push(K_RESP, cyc + 20, 32'hA000_00C2);
    issue(12'h308, c0);
    invalidate = 1'b0;
    goto(c0 + 24);
    hit(12'h30C, 32'hA000_00C3);

    // Stand-alone invalidate in IDLE
    invalidate = 1'b1;
    goto(cyc + 1);
    invalidate = 1'b0;
    miss(12'h310, 32'hA000_00C4);

    // Reset while the fifth word is on the bus
    push(K_REQ, cyc + 1, 32'h0001_0400);
    issue(12'h400, c0);
    goto(c0 + 8);
    reset = 1'b1;
    goto(c0 + 9);
    reset = 1'b0;
    @(negedge clock);
    chk("midrst_cpu_valid", {31'd0, cpu_valid}, 32'd0);
    chk("midrst_cpu_instr", cpu_instr, 32'd0);
    chk("midrst_fill_error", {31'd0, fill_error}, 32'd0);
    chk("midrst_im_enable", {31'd0, IM_enable}, 32'd0);
    chk("midrst_im_address", {20'd0, IM_address}, 32'd0);
    chk("midrst_fill_busy", {31'd0, fill_busy}, 32'd0);
    goto(c0 + 25);
    miss(12'h404, 32'hA000_0101);

    // Every expected event must have been seen
    goto(cyc + 5);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL pending_events: got %0d outstanding, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/im_line_fill.md
IM_LINE_FILL -- requirements
Module: im_line_fill

Interface
REQ-001 SHALL have parameter data_size, default 32, instruction word width.
REQ-002 SHALL have parameter mem_size_bit, default 12, byte-address width.
REQ-003 SHALL have parameter line_words, default 16, words per line; line = 64 bytes, base = address & ~63.
REQ-004 SHALL have parameter timeout, default 31, max cycles in WAIT with IM_ready low.
REQ-005 Port clock, input, 1, single clock; all logic on posedge clock.
REQ-006 Port reset, input, 1, synchronous, active-high.
REQ-007 Port cpu_req, input, 1, fetch request; sampled only in IDLE.
REQ-008 Port cpu_addr, input, mem_size_bit, fetch byte address; bits [1:0] ignored.
REQ-009 Port cpu_instr, output, data_size, fetched word; meaningful only while cpu_valid=1.
REQ-010 Port cpu_valid, output, 1, one-cycle pulse; cpu_instr is valid.
REQ-011 Port invalidate, input, 1, discards the buffered line.
REQ-012 Port fill_busy, output, 1, high in any state other than IDLE.
REQ-013 Port fill_error, output, 1, one-cycle pulse on an aborted fill.
REQ-014 Port IM_enable, output, 1, memory enable.
REQ-015 Port IM_read, output, 1, memory read strobe.
REQ-016 Port IM_write, output, 1, tied 0.
REQ-017 Port IM_address, output, mem_size_bit, line base byte address.
REQ-018 Port IM_in, output, data_size, tied 0.
REQ-019 Port IM_out, input, data_size, burst data from memory.
REQ-020 Port IM_ready, input, 1, high for each consecutive burst word.

Function
REQ-021 SHALL hold one line buffer: line_words x data_size data, a tag (cpu_addr[mem_size_bit-1:6]) and a valid bit.
REQ-022 SHALL implement states IDLE, REQ, WAIT, FILL.
REQ-023 IDLE, cpu_req=1, valid=1, tag match (hit): next cycle cpu_valid=1, cpu_instr=line[cpu_addr[5:2]]; stay IDLE.
REQ-024 IDLE, cpu_req=1, miss: latch cpu_addr, go to REQ next cycle.
REQ-025 REQ: IM_enable=1, IM_read=1 and IM_address={latched tag,6'b0} for exactly one cycle; clear valid; go to WAIT.
REQ-026 Outside REQ: IM_enable=0, IM_read=0, IM_address holds its last value.
REQ-027 WAIT: on the first IM_ready=1, store IM_out to line[0], set word count=1, go to FILL.
REQ-028 FILL: on each IM_ready=1, store IM_out to line[count], increment count (4 bits, wraps 15->0).
REQ-029 Storing word line_words-1: set valid and tag, pulse cpu_valid next cycle with line[latched index], go to IDLE.
REQ-030 Miss latency: cpu_valid is asserted exactly one cycle after the cycle the 16th word is captured.
REQ-031 WAIT exceeding timeout cycles with IM_ready=0: pulse fill_error, keep valid=0, go to IDLE, no cpu_valid.
REQ-032 IM_ready=0 in FILL before word 16 (early drop): pulse fill_error, valid=0, go to IDLE.
REQ-033 IM_ready high after the 16th word: ignored; the line is not overwritten.
REQ-034 cpu_req while fill_busy=1: ignored; the requester re-presents it after cpu_valid or fill_error.
REQ-035 invalidate in IDLE: clears valid next cycle; invalidate outranks a same-cycle hit, so that request is treated as a miss.
REQ-036 invalidate during REQ, WAIT or FILL: the fill completes and cpu_valid is still delivered, but valid is left 0.

Reset
REQ-037 When reset=1 at a posedge: state=IDLE, valid=0, count=0; cpu_valid, fill_error, IM_enable and IM_read = 0; IM_address=0; cpu_instr=0.
REQ-038 Reset mid-fill: abort immediately with no cpu_valid and no fill_error; later IM_ready pulses are ignored while in IDLE.
REQ-039 Line buffer data is not cleared by reset.

Verification
REQ-040 Bench model: memory with 2 wait states, 16-word burst, mem[i]=32'hA000_0000+i.
REQ-041 Cold miss: cpu_req, addr 12'h048 -> one-cycle IM_enable/IM_read with IM_address=12'h040; after the burst, cpu_valid with cpu_instr=A000_0012.
REQ-042 Hit: then cpu_req, addr 12'h07C -> cpu_valid next cycle, cpu_instr=A000_001F, no IM_enable.
REQ-043 Conflict miss: cpu_req, addr 12'h084 -> refill at 12'h080, cpu_instr=A000_0021; old line lost.
REQ-044 Timeout: memory never raises IM_ready -> fill_error after 32 WAIT cycles, no cpu_valid, next request refetches.
REQ-045 Early drop: IM_ready falls after 9 words -> fill_error, valid=0; invalidate during a good fill -> cpu_valid delivered, next same-line request misses.
REQ-046 Reset asserted during FILL word 5 -> all outputs 0 next cycle, fill_busy=0, no cpu_valid.
